// File: rtl/ysyx_23060203_icache_sa_pkg.sv
// Shared types for the set-associative I-cache: FSM states and AXI read encodings.
package ysyx_23060203_icache_sa_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned LEN_W  = 8;

  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_4B     = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MMU  = 2'd1,
    REQ  = 2'd2,
    RESP = 2'd3
  } icache_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } axi_ar_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } axi_r_t;

  function automatic logic resp_ok(input logic [1:0] resp);
    return resp == RESP_OKAY;
  endfunction

endpackage

// File: rtl/ysyx_23060203_icache_sa_if.sv
// AXI read channel (AR + R) between the I-cache and the memory interconnect.
interface ysyx_23060203_icache_sa_if;
  import ysyx_23060203_icache_sa_pkg::*;

  logic    arvalid;
  logic    arready;
  axi_ar_t ar;
  logic    rvalid;
  logic    rready;
  axi_r_t  r;

  modport master (output arvalid, ar, rready, input arready, rvalid, r);
  modport slave  (input arvalid, ar, rready, output arready, rvalid, r);
endinterface

// File: rtl/ysyx_23060203_icache_way.sv
// One cache way: valid bits (reset), tag and data arrays (no reset), read and fill ports.
module ysyx_23060203_icache_way #(
  parameter int unsigned OFFSET_W = 6,
  parameter int unsigned INDEX_W  = 5
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          fencei,
  input  logic [INDEX_W-1:0]            rd_index,
  input  logic [OFFSET_W-3:0]           rd_word,
  input  logic [31-OFFSET_W-INDEX_W:0]  rd_tag,
  output logic                          hit_c,
  output logic                          vld_c,
  output logic [31:0]                   data_c,
  input  logic                          wr_en,
  input  logic [INDEX_W-1:0]            wr_index,
  input  logic [OFFSET_W-3:0]           wr_word,
  input  logic [31:0]                   wr_data,
  input  logic                          fill_done,
  input  logic                          fill_valid,
  input  logic [31-OFFSET_W-INDEX_W:0]  fill_tag
);
  localparam int unsigned TAG_W = 32 - OFFSET_W - INDEX_W;
  localparam int unsigned SETS  = 1 << INDEX_W;
  localparam int unsigned WORDS = 1 << (OFFSET_W - 2);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS][WORDS];

  // Valid bits: fencei clears everything; a completed fill writes good/bad status.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (fencei) begin
      valid_q <= '0;
    end else if (fill_done) begin
      valid_q[wr_index] <= fill_valid;
    end
  end

  // Data beats and the tag land in storage without reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      data_q[wr_index][wr_word] <= wr_data;
    end
    if (fill_done) begin
      tag_q[wr_index] <= fill_tag;
    end
  end

  assign vld_c  = valid_q[rd_index];
  assign hit_c  = vld_c && (tag_q[rd_index] == rd_tag);
  assign data_c = data_q[rd_index][rd_word];

endmodule

// File: rtl/ysyx_23060203_icache_sa.sv
// Set-associative instruction cache: zero-latency hits, MMU lookup then wrapping AXI line fill.
module ysyx_23060203_icache_sa
  import ysyx_23060203_icache_sa_pkg::*;
#(
  parameter int unsigned OFFSET_W = 6,
  parameter int unsigned INDEX_W  = 5,
  parameter int unsigned WAYS     = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              fencei,
  input  logic [31:0]                       addr,
  output logic                              hit,
  output logic [31:0]                       inst,
  output logic                              access_fault,
  output logic                              mmu_valid,
  output logic [31:0]                       mmu_vaddr,
  input  logic                              mmu_hit,
  input  logic [31:0]                       mmu_paddr,
  ysyx_23060203_icache_sa_if.master         mem_r
);
  localparam int unsigned TAG_W  = 32 - OFFSET_W - INDEX_W;
  localparam int unsigned WORD_W = OFFSET_W - 2;
  localparam int unsigned WORDS  = 1 << WORD_W;
  localparam int unsigned SETS   = 1 << INDEX_W;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [TAG_W-1:0]   addr_tag;
  logic [INDEX_W-1:0] addr_index;
  logic [WORD_W-1:0]  addr_word;
  logic [1:0]         unused_addr_lsb;

  icache_state_e      state;
  logic [31:0]        paddr;
  logic [INDEX_W-1:0] fill_index;
  logic [TAG_W-1:0]   fill_tag;
  logic [WORD_W-1:0]  fill_ptr;
  logic [WAY_W-1:0]   victim;
  logic [WAY_W-1:0]   victim_c;
  logic               fence_flag;
  logic               err_flag;
  logic               arvalid_q;
  logic               rready_q;
  logic [WAY_W-1:0]   rr_ptr [SETS];

  logic [WAYS-1:0]    way_hit;
  logic [WAYS-1:0]    way_vld;
  logic [31:0]        way_data [WAYS];

  logic               beat_c;
  logic               last_beat_c;
  logic               beat_bad_c;
  logic               fill_good_c;

  assign addr_tag        = addr[31 -: TAG_W];
  assign addr_index      = addr[OFFSET_W +: INDEX_W];
  assign addr_word       = addr[2 +: WORD_W];
  assign unused_addr_lsb = addr[1:0];
  assign mmu_vaddr       = addr;

  assign beat_c      = rready_q && mem_r.rvalid;
  assign last_beat_c = beat_c && mem_r.r.last;
  assign beat_bad_c  = !resp_ok(mem_r.r.resp);
  // A fence anywhere since the MMU step, or on the rlast edge itself, poisons the fill.
  assign fill_good_c = !err_flag && !beat_bad_c && !fence_flag && !fencei;

  assign mem_r.arvalid  = arvalid_q;
  assign mem_r.rready   = rready_q;
  assign mem_r.ar.addr  = paddr;
  assign mem_r.ar.id    = '0;
  assign mem_r.ar.len   = LEN_W'(WORDS - 1);
  assign mem_r.ar.size  = SIZE_4B;
  assign mem_r.ar.burst = BURST_WRAP;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    ysyx_23060203_icache_way #(
      .OFFSET_W (OFFSET_W),
      .INDEX_W  (INDEX_W)
    ) u_way (
      .clock      (clock),
      .reset      (reset),
      .fencei     (fencei),
      .rd_index   (addr_index),
      .rd_word    (addr_word),
      .rd_tag     (addr_tag),
      .hit_c      (way_hit[w]),
      .vld_c      (way_vld[w]),
      .data_c     (way_data[w]),
      .wr_en      (beat_c && (victim == WAY_W'(w))),
      .wr_index   (fill_index),
      .wr_word    (fill_ptr),
      .wr_data    (mem_r.r.data),
      .fill_done  (last_beat_c && (victim == WAY_W'(w))),
      .fill_valid (fill_good_c),
      .fill_tag   (fill_tag)
    );
  end

  // AND-OR select of the hitting way.
  always_comb begin
    hit  = 1'b0;
    inst = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      hit  = hit | way_hit[w];
      inst = inst | (way_data[w] & {32{way_hit[w]}});
    end
  end

  // Victim: lowest invalid way of the set, otherwise the set's round-robin pointer.
  always_comb begin
    victim_c = rr_ptr[addr_index];
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!way_vld[w]) victim_c = WAY_W'(w);
    end
  end

  // Miss FSM with registered handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      mmu_valid    <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      access_fault <= 1'b0;
      paddr        <= '0;
      fill_index   <= '0;
      fill_tag     <= '0;
      fill_ptr     <= '0;
      victim       <= '0;
      fence_flag   <= 1'b0;
      err_flag     <= 1'b0;
      for (int s = 0; s < int'(SETS); s++) rr_ptr[s] <= '0;
    end else begin
      access_fault <= 1'b0;
      if (fencei && (state != IDLE)) fence_flag <= 1'b1;
      case (state)
        IDLE: begin
          if (!hit) begin
            state      <= MMU;
            mmu_valid  <= 1'b1;
            fence_flag <= 1'b0;
          end
        end
        MMU: begin
          if (mmu_hit) begin
            state      <= REQ;
            mmu_valid  <= 1'b0;
            arvalid_q  <= 1'b1;
            paddr      <= mmu_paddr;
            fill_index <= addr_index;
            fill_tag   <= addr_tag;
            fill_ptr   <= addr_word;
            victim     <= victim_c;
            err_flag   <= 1'b0;
          end
        end
        REQ: begin
          if (mem_r.arready) begin
            state     <= RESP;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        RESP: begin
          if (beat_c) begin
            fill_ptr <= fill_ptr + WORD_W'(1);
            if (beat_bad_c) err_flag <= 1'b1;
            if (mem_r.r.last) begin
              state        <= IDLE;
              rready_q     <= 1'b0;
              access_fault <= err_flag || beat_bad_c;
              if (fill_good_c) begin
                rr_ptr[fill_index] <= WAY_W'((32'(rr_ptr[fill_index]) + 32'd1) % WAYS);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  logic [63:0] perf_icache_mem;
  logic [63:0] perf_icache_miss;

  // Perf events: busy (non-IDLE) cycles and line requests issued.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_icache_mem  <= '0;
      perf_icache_miss <= '0;
    end else begin
      if (state != IDLE) perf_icache_mem <= perf_icache_mem + 64'd1;
      if (arvalid_q && mem_r.arready) perf_icache_miss <= perf_icache_miss + 64'd1;
    end
  end

  a_single_way_hit: assert property (@(posedge clock) disable iff (reset) $onehot0(way_hit));
`endif

endmodule

// File: tb/tb_ysyx_23060203_icache_sa.sv
// Directed bench: identity MMU, wrapping AXI slave model, hand-computed expectations.
module tb_ysyx_23060203_icache_sa;
  import ysyx_23060203_icache_sa_pkg::*;

  logic        clock;
  logic        reset;
  logic        fencei;
  logic [31:0] addr;
  logic        hit;
  logic [31:0] inst;
  logic        access_fault;
  logic        mmu_valid;
  logic [31:0] mmu_vaddr;
  logic        mmu_hit;
  logic [31:0] mmu_paddr;

  ysyx_23060203_icache_sa_if mem_r_if ();

  ysyx_23060203_icache_sa dut (
    .clock        (clock),
    .reset        (reset),
    .fencei       (fencei),
    .addr         (addr),
    .hit          (hit),
    .inst         (inst),
    .access_fault (access_fault),
    .mmu_valid    (mmu_valid),
    .mmu_vaddr    (mmu_vaddr),
    .mmu_hit      (mmu_hit),
    .mmu_paddr    (mmu_paddr),
    .mem_r        (mem_r_if)
  );

  // Identity translation answering in the same cycle.
  assign mmu_hit   = mmu_valid;
  assign mmu_paddr = mmu_vaddr;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  // Slave model state
  int      ar_count   = 0;
  int      fills_done = 0;
  int      err_beat   = -1;
  int      cur_k      = 0;
  int      start_word = 0;
  bit      busy       = 0;
  bit      ar_fire    = 0;
  bit      r_fire     = 0;
  logic [31:0] line_base = '0;
  axi_ar_t last_ar;
  int      beat_words[$];

  // AXI slave: acts on the falling edge, handshakes complete on the next rising edge.
  initial begin
    mem_r_if.arready = 1'b0;
    mem_r_if.rvalid  = 1'b0;
    mem_r_if.r       = '0;
    last_ar          = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        mem_r_if.arready = 1'b0;
        mem_r_if.rvalid  = 1'b0;
        mem_r_if.r       = '0;
        busy = 0; ar_fire = 0; r_fire = 0; cur_k = 0;
      end else begin
        if (ar_fire) begin
          ar_fire = 0; busy = 1; cur_k = 0;
        end else if (r_fire) begin
          r_fire = 0;
          beat_words.push_back((start_word + cur_k) % 16);
          if (cur_k == 15) begin busy = 0; fills_done++; end
          else cur_k++;
        end
        if (!busy) begin
          mem_r_if.rvalid  = 1'b0;
          mem_r_if.r.last  = 1'b0;
          mem_r_if.arready = mem_r_if.arvalid;
          if (mem_r_if.arvalid) begin
            ar_fire    = 1;
            last_ar    = mem_r_if.ar;
            ar_count++;
            start_word = int'(mem_r_if.ar.addr[5:2]);
            line_base  = {mem_r_if.ar.addr[31:6], 6'b0};
          end
        end else begin
          mem_r_if.arready = 1'b0;
          mem_r_if.rvalid  = 1'b1;
          mem_r_if.r.data  = memw(line_base | (32'((start_word + cur_k) % 16) << 2));
          mem_r_if.r.resp  = (cur_k == err_beat) ? RESP_SLVERR : RESP_OKAY;
          mem_r_if.r.last  = (cur_k == 15);
          r_fire = mem_r_if.rready;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_fills(input int target);
    for (int i = 0; i < 300 && fills_done < target; i++) tick();
    check("fill_done", 32'(fills_done), 32'(target));
  endtask

  task automatic wait_ars(input int target);
    for (int i = 0; i < 300 && ar_count < target; i++) tick();
    check("ar_issued", 32'(ar_count), 32'(target));
  endtask

  task automatic wait_beat(input int k);
    for (int i = 0; i < 300 && !(busy && cur_k == k); i++) tick();
    check("beat_reached", busy ? 32'(cur_k) : 32'hFFFF_FFFF, 32'(k));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  localparam logic [31:0] A_COLD = 32'h3000_0044;
  localparam logic [31:0] A_WRAP = 32'h3000_00B8;
  localparam logic [31:0] A_S3_0 = 32'h3000_00C0;
  localparam logic [31:0] A_S3_1 = 32'h3000_08C0;
  localparam logic [31:0] A_S3_2 = 32'h3000_10C0;
  localparam logic [31:0] A_FEN  = 32'h3000_0100;
  localparam logic [31:0] A_ERR  = 32'h3000_0140;
  localparam logic [31:0] A_RST  = 32'h3000_0180;

  initial begin
    int nf;
    int na;
    reset  = 1'b1;
    fencei = 1'b0;
    addr   = A_COLD;
    tick();
    tick();
    // Reset state
    check("rst_mmu_valid", 32'(mmu_valid), 32'd0);
    check("rst_arvalid", 32'(mem_r_if.arvalid), 32'd0);
    check("rst_rready", 32'(mem_r_if.rready), 32'd0);
    check("rst_access_fault", 32'(access_fault), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_mmu_valid", 32'(mmu_valid), 32'd0);

    // Cold miss
    tick();
    check("cold_mmu_valid", 32'(mmu_valid), 32'd1);
    check("cold_mmu_vaddr", mmu_vaddr, A_COLD);
    wait_ars(1);
    check("cold_araddr", last_ar.addr, A_COLD);
    check("cold_arlen", 32'(last_ar.len), 32'd15);
    check("cold_arburst", 32'(last_ar.burst), 32'd2);
    check("cold_arsize", 32'(last_ar.size), 32'd2);
    check("cold_arid", 32'(last_ar.id), 32'd0);
    wait_fills(1);
    check("cold_hit", 32'(hit), 32'd1);
    check("cold_inst", inst, memw(A_COLD));
    check("cold_first_beat", 32'(beat_words[0]), 32'd1);

    // Wrap order: miss at word 14
    beat_words.delete();
    addr = A_WRAP;
    wait_fills(2);
    check("wrap_hit", 32'(hit), 32'd1);
    for (int k = 0; k < 16; k++) check("wrap_order", 32'(beat_words[k]), 32'((14 + k) % 16));
    for (int i = 0; i < 16; i++) begin
      addr = 32'h3000_0080 + 32'(i * 4);
      #1;
      check("wrap_rd_hit", 32'(hit), 32'd1);
      check("wrap_rd_inst", inst, memw(32'h3000_0080 + 32'(i * 4)));
      tick();
    end

    // Replacement on set 3
    addr = A_S3_0;
    wait_fills(3);
    addr = A_S3_1;
    wait_fills(4);
    addr = A_S3_2;
    wait_fills(5);
    addr = A_S3_1;
    #1;
    check("repl_b_hit", 32'(hit), 32'd1);
    check("repl_b_inst", inst, memw(A_S3_1));
    addr = A_S3_2;
    #1;
    check("repl_c_hit", 32'(hit), 32'd1);
    addr = A_S3_0;
    #1;
    check("repl_a_evicted", 32'(hit), 32'd0);
    wait_fills(6);
    addr = A_S3_2;
    #1;
    check("repl_c_kept", 32'(hit), 32'd1);
    addr = A_S3_1;
    #1;
    check("repl_b_evicted", 32'(hit), 32'd0);
    wait_fills(7);

    // fencei during RESP
    nf = fills_done;
    na = ar_count;
    addr = A_FEN;
    wait_beat(4);
    fencei = 1'b1;
    tick();
    fencei = 1'b0;
    wait_fills(nf + 1);
    check("fence_not_valid", 32'(hit), 32'd0);
    wait_ars(na + 2);
    check("fence_refetch_addr", last_ar.addr, A_FEN);
    wait_fills(nf + 2);
    check("fence_refill_hit", 32'(hit), 32'd1);
    check("fence_refill_inst", inst, memw(A_FEN));
    addr = A_COLD;
    #1;
    check("fence_set1_miss", 32'(hit), 32'd0);
    addr = A_WRAP;
    #1;
    check("fence_set2_miss", 32'(hit), 32'd0);
    addr = A_S3_1;
    #1;
    check("fence_set3_miss", 32'(hit), 32'd0);
    addr = A_FEN;
    tick();

    // SLVERR on beat 5
    nf = fills_done;
    err_beat = 5;
    addr = A_ERR;
    wait_fills(nf + 1);
    check("fault_pulse", 32'(access_fault), 32'd1);
    check("fault_no_hit", 32'(hit), 32'd0);
    err_beat = -1;
    tick();
    check("fault_pulse_end", 32'(access_fault), 32'd0);
    check("fault_still_miss", 32'(hit), 32'd0);
    wait_fills(nf + 2);
    check("fault_refill_hit", 32'(hit), 32'd1);
    check("fault_refill_inst", inst, memw(A_ERR));

    // Reset in the middle of a burst
    addr = A_RST;
    wait_beat(3);
    reset = 1'b1;
    #1;
    check("midrst_rready", 32'(mem_r_if.rready), 32'd0);
    check("midrst_arvalid", 32'(mem_r_if.arvalid), 32'd0);
    check("midrst_mmu_valid", 32'(mmu_valid), 32'd0);
    check("midrst_hit", 32'(hit), 32'd0);
    tick();
    tick();
    nf = fills_done;
    reset = 1'b0;
    #1;
    check("postrst_mmu_valid", 32'(mmu_valid), 32'd0);
    check("postrst_miss", 32'(hit), 32'd0);
    addr = A_ERR;
    #1;
    check("postrst_other_miss", 32'(hit), 32'd0);
    addr = A_RST;
    tick();
    check("postrst_idle_to_mmu", 32'(mmu_valid), 32'd1);
    wait_fills(nf + 1);
    check("postrst_fill_hit", 32'(hit), 32'd1);
    check("postrst_fill_inst", inst, memw(A_RST));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
